seq_alu: RTL and testbench

Parametrised multicycle ALU for the RISC-V multicycle datapath. It performs the single-cycle integer ops in one registered cycle and adds iterative multiply, divide and remainder. A start/busy/done handshake lets the controller FSM wait on long ops. Result flags `zero`/`sign` are derived from the registered result.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_basic.sv | 36 +++
 rtl/seq_alu.sv | 122 ++++++++++++
 tb/tb_seq_alu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state type and op classification for seq_alu.
package seq_alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_MUL   = 4'b1000;
   localparam logic [3:0] ALU_MULHU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_REM   = 4'b1110;
   localparam logic [3:0] ALU_REMU  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   function automatic logic is_iterative(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU) || (op[3:2] == 2'b11);
   endfunction

   function automatic logic is_signed_div(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/seq_alu_basic.sv
// Combinational single-cycle ALU ops; undefined codes yield zero.
module seq_alu_basic
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic lt;

   always_comb begin
      y  = '0;
      lt = 1'b0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLT: begin
            lt = $signed(a) < $signed(b);
            y  = {{(WIDTH-1){1'b0}}, lt};
         end
         ALU_SLTU: begin
            lt = a < b;
            y  = {{(WIDTH-1){1'b0}}, lt};
         end
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: registered single-cycle ops plus iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             sign
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [3:0]         op_q;
   logic               a_neg;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0]   basic_y, a_mag, dvs, q, r, qf, rf, res;
   logic [WIDTH:0]     sum, rsh, diff;
   logic               is_mul, sdiv;

   seq_alu_basic #(.WIDTH(WIDTH)) u_basic (
      .op (op),
      .a  (in1),
      .b  (in2),
      .y  (basic_y)
   );

   assign busy = (state != S_IDLE);
   assign zero = (out == '0);
   assign sign = out[WIDTH-1];

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start && is_iterative(op)) state_nx = S_CALC;
         S_CALC:   if (cnt == LAST) state_nx = S_RESULT;
         S_RESULT: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // acc is {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide
   always_comb begin
      is_mul = (op_q[3:2] == 2'b10);
      sdiv   = is_signed_div(op_q);
      a_mag  = (is_signed_div(op) && in1[WIDTH-1]) ? -in1 : in1;
      dvs    = (sdiv && b_q[WIDTH-1]) ? -b_q : b_q;
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
      rsh    = acc[2*WIDTH-1:WIDTH-1];
      diff   = rsh - {1'b0, dvs};
      if (is_mul)
         acc_nx = {sum, acc[WIDTH-1:1]};
      else if (!diff[WIDTH])
         acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_nx = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      q  = acc[WIDTH-1:0];
      r  = acc[2*WIDTH-1:WIDTH];
      // zero divisor leaves |dividend| in r, so only the quotient needs forcing
      qf = (b_q == '0) ? '1 : ((sdiv && (a_neg ^ b_q[WIDTH-1])) ? -q : q);
      rf = (sdiv && a_neg) ? -r : r;
      if (is_mul)
         res = op_q[0] ? r : q;
      else
         res = op_q[1] ? rf : qf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_neg <= 1'b0;
         b_q   <= '0;
         acc   <= '0;
         out   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (is_iterative(op)) begin
                     op_q  <= op;
                     a_neg <= in1[WIDTH-1];
                     b_q   <= in2;
                     cnt   <= '0;
                     acc   <= {{WIDTH{1'b0}}, (op[2] ? a_mag : in1)};
                  end else begin
                     out  <= basic_y;
                     done <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               acc <= acc_nx;
               cnt <= cnt + CW'(1);
            end
            S_RESULT: begin
               out  <= res;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32 and WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        s32, s8;
   logic [3:0]  op32, op8;
   logic [31:0] a32, b32, out32;
   logic [7:0]  a8, b8, out8;
   logic        busy32, done32, zero32, sign32;
   logic        busy8, done8, zero8, sign8;

   seq_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(s32), .op(op32), .in1(a32), .in2(b32),
      .busy(busy32), .done(done32), .out(out32), .zero(zero32), .sign(sign32)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .op(op8), .in1(a8), .in2(b8),
      .busy(busy8), .done(done8), .out(out8), .zero(zero8), .sign(sign8)
   );

   typedef struct {
      int          due;
      logic [63:0] val;
   } exp_t;

   exp_t        pend0[$];
   exp_t        pend1[$];
   logic [63:0] exp_out[2];
   int          busy_lo[2];
   int          busy_hi[2];
   int          last_due[2];
   int          cyc = 0;
   int          vectors = 0;
   int          errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] ai,
                                         input logic [63:0] bi, input int w);
      logic [63:0] m, a, b, r;
      longint      sa, sb;
      m  = (64'd1 << w) - 64'd1;
      a  = ai & m;
      b  = bi & m;
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      case (op)
         ALU_ADD:   r = a + b;
         ALU_SUB:   r = a - b;
         ALU_AND:   r = a & b;
         ALU_OR:    r = a | b;
         ALU_XOR:   r = a ^ b;
         ALU_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
         ALU_SLTU:  r = (a < b) ? 64'd1 : 64'd0;
         ALU_MUL:   r = a * b;
         ALU_MULHU: r = (a * b) >> w;
         ALU_DIV:   r = (b == 0) ? m : 64'(sa / sb);
         ALU_DIVU:  r = (b == 0) ? m : a / b;
         ALU_REM:   r = (b == 0) ? a : 64'(sa % sb);
         ALU_REMU:  r = (b == 0) ? a : a % b;
         default:   r = 64'd0;
      endcase
      return r & m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // compare process: every cycle, both DUTs
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [63:0] ao;
         logic        ad, az, as, ab, xd, xb;
         int          w;
         w = (d == 0) ? 32 : 8;
         if (d == 0) begin
            ao = {32'd0, out32}; ad = done32; az = zero32; as = sign32; ab = busy32;
         end else begin
            ao = {56'd0, out8};  ad = done8;  az = zero8;  as = sign8;  ab = busy8;
         end
         xd = 1'b0;
         if (d == 0 && pend0.size() > 0 && pend0[0].due == cyc) begin
            exp_out[0] = pend0[0].val;
            void'(pend0.pop_front());
            xd = 1'b1;
         end
         if (d == 1 && pend1.size() > 0 && pend1[0].due == cyc) begin
            exp_out[1] = pend1[0].val;
            void'(pend1.pop_front());
            xd = 1'b1;
         end
         xb = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
         check($sformatf("done%0d", w), {63'd0, ad}, {63'd0, xd});
         check($sformatf("out%0d", w),  ao, exp_out[d]);
         check($sformatf("zero%0d", w), {63'd0, az}, {63'd0, (exp_out[d] == 64'd0)});
         check($sformatf("sign%0d", w), {63'd0, as}, {63'd0, exp_out[d][w-1]});
         check($sformatf("busy%0d", w), {63'd0, ab}, {63'd0, xb});
      end
   end

   task automatic issue(input int d, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b);
      int w, due;
      @(negedge clk); #1;
      w = (d == 0) ? 32 : 8;
      if (d == 0) begin s32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
      else        begin s8  = 1'b1; op8  = op; a8  = a[7:0];  b8  = b[7:0];  end
      due = cyc + 1 + (is_iterative(op) ? w + 1 : 0);
      if (is_iterative(op)) begin
         busy_lo[d] = cyc + 1;
         busy_hi[d] = cyc + 1 + w;
      end
      last_due[d] = due;
      if (d == 0) pend0.push_back('{due, model(op, a, b, w)});
      else        pend1.push_back('{due, model(op, a, b, w)});
   endtask

   task automatic idle();
      @(negedge clk); #1;
      s32 = 1'b0;
      s8  = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int due;
      due = last_due[d];
      while (cyc <= due) @(negedge clk);
      #1;
   endtask

   task automatic run(input int d, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b);
      issue(d, op, a, b);
      idle();
      wait_done(d);
   endtask

   initial begin
      rst_n = 1'b0;
      s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
      for (int d = 0; d < 2; d++) begin
         exp_out[d] = 64'd0; busy_lo[d] = 1; busy_hi[d] = 0; last_due[d] = 0;
      end

      // hand-computed pins on the reference model
      check("pin_add",   model(ALU_ADD,   64'd7, 64'd5, 32), 64'd12);
      check("pin_slt",   model(ALU_SLT,   64'hFFFF_FFFF, 64'd1, 32), 64'd1);
      check("pin_sltu",  model(ALU_SLTU,  64'hFFFF_FFFF, 64'd1, 32), 64'd0);
      check("pin_mul",   model(ALU_MUL,   64'hFFFF_FFFF, 64'hFFFF_FFFF, 32), 64'h1);
      check("pin_mulhu", model(ALU_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32), 64'hFFFF_FFFE);
      check("pin_div",   model(ALU_DIV,   64'hFFFF_FFF9, 64'd2, 32), 64'hFFFF_FFFD);
      check("pin_rem",   model(ALU_REM,   64'hFFFF_FFF9, 64'd2, 32), 64'hFFFF_FFFF);
      check("pin_divu",  model(ALU_DIVU,  64'd100, 64'd7, 32), 64'd14);
      check("pin_remu",  model(ALU_REMU,  64'd100, 64'd7, 32), 64'd2);
      check("pin_ovf",   model(ALU_DIV,   64'h8000_0000, 64'hFFFF_FFFF, 32), 64'h8000_0000);
      check("pin_ovfr",  model(ALU_REM,   64'h8000_0000, 64'hFFFF_FFFF, 32), 64'd0);
      check("pin_div0",  model(ALU_DIV,   64'd42, 64'd0, 32), 64'hFFFF_FFFF);
      check("pin_rem0",  model(ALU_REM,   64'd42, 64'd0, 32), 64'd42);
      check("pin_mul8",  model(ALU_MUL,   64'd15, 64'd17, 8), 64'hFF);
      check("pin_div8",  model(ALU_DIV,   64'h80, 64'hFF, 8), 64'h80);

      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(0, ALU_ADD, 64'd7, 64'd5);
      run(0, ALU_SUB, 64'd5, 64'd5);
      run(0, ALU_SLT, 64'hFFFF_FFFF, 64'd1);
      run(0, ALU_SLTU, 64'hFFFF_FFFF, 64'd1);

      // back-to-back single-cycle ops, including undefined codes
      issue(0, ALU_ADD,  64'h7FFF_FFFF, 64'd1);
      issue(0, ALU_SUB,  64'd0, 64'd1);
      issue(0, ALU_AND,  64'hF0F0_1234, 64'hFF00_FF00);
      issue(0, ALU_OR,   64'hF0F0_1234, 64'h0F0F_0000);
      issue(0, ALU_XOR,  64'hAAAA_5555, 64'hFFFF_0000);
      issue(0, ALU_SLT,  64'd3, 64'hFFFF_FFFE);
      issue(0, ALU_SLTU, 64'd3, 64'hFFFF_FFFE);
      issue(0, 4'b0111,  64'd9, 64'd9);
      issue(0, 4'b1010,  64'd9, 64'd9);
      idle();
      repeat (2) @(negedge clk);

      // multiply with start/operand toggling while busy
      issue(0, ALU_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         s32 = i[0]; op32 = (i < 3) ? ALU_ADD : ALU_DIVU;
         a32 = $urandom; b32 = $urandom;
      end
      s32 = 1'b0;
      wait_done(0);
      run(0, ALU_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);

      run(0, ALU_DIV,  64'hFFFF_FFF9, 64'd2);
      run(0, ALU_REM,  64'hFFFF_FFF9, 64'd2);
      run(0, ALU_DIVU, 64'd100, 64'd7);
      run(0, ALU_REMU, 64'd100, 64'd7);
      run(0, ALU_DIV,  64'h8000_0000, 64'hFFFF_FFFF);
      run(0, ALU_REM,  64'h8000_0000, 64'hFFFF_FFFF);
      run(0, ALU_DIV,  64'd42, 64'd0);
      run(0, ALU_REM,  64'd42, 64'd0);
      run(0, ALU_DIV,  64'd1000, 64'hFFFF_FFF9);
      run(0, ALU_REM,  64'd1000, 64'hFFFF_FFF9);

      // reset in the middle of an iterative op
      issue(0, ALU_DIVU, 64'd12345, 64'd11);
      idle();
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      pend0.delete();
      pend1.delete();
      for (int d = 0; d < 2; d++) begin
         exp_out[d] = 64'd0; busy_lo[d] = 1; busy_hi[d] = 0;
      end
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(0, ALU_DIVU, 64'd100, 64'd7);

      // WIDTH=8 instance
      run(1, ALU_MUL,   64'd15, 64'd17);
      run(1, ALU_DIV,   64'h80, 64'hFF);
      run(1, ALU_REM,   64'h80, 64'hFF);
      run(1, ALU_MULHU, 64'hFF, 64'hFF);
      run(1, ALU_SUB,   64'h00, 64'h01);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
